game_flow_ctrl: RTL
===================

Name: game_flow_ctrl

Overview:
Parametrised game-flow controller for the asteroids top level. It replaces the single-player opening-screen counter, the lives counter and the animation divider with one frame-synchronous FSM. The FSM covers intro zoom, play, respawn delay, round-robin turns for N players and game over with restart. All timing counts vsync pulses; it drives the asteroid quad, the ship, and the lives and banner sprite draw masks.

Parameters:
NUM_PLAYERS, 2, players alternating turns (1..4)
NUM_LIVES, 3, starting lives per player
MAX_NUM_LIVES, 10, bonus saturation limit
INTRO_FRAMES, 511, vsyncs spent in INTRO (≥ ZOOM_FRAMES+1)
ZOOM_FRAMES, 255, vsync count at which start_done sets
RESPAWN_FRAMES, 120, vsyncs in RESPAWN before the next turn
ANIM_DIV, 12, vsyncs per anim_pulse

Ports:
clk  in  1  25 MHz pixel clock
resetN  in  1  asynchronous active-low reset
vsync  in  1  one-cycle frame-start pulse
die  in  1  ship collision pulse
bonus  in  1  extra-life pulse
level_clear  in  1  all asteroids destroyed, pulse
restart  in  1  leave GAME_OVER, pulse
state  out  3  game_state_t
intro_scale  out  8  intro_cnt[7:0], zoom scale for the title sprite
start_done  out  1  title sprite hidden
game_begin  out  1  high in PLAY
new_level  out  1  one-cycle asteroid respawn request
game_over  out  1  high in GAME_OVER
cur_player  out  PW=max(1,$clog2(NUM_PLAYERS))  active player
lives  out  NUM_PLAYERS*LW, LW=$clog2(MAX_NUM_LIVES+1)  packed per-player lives
level  out  8  current level, saturates at 255
anim_pulse  out  1  one cycle every ANIM_DIV vsyncs

Behaviour:
- Reset values (async, all registered outputs):
  - state=INTRO; intro_cnt=0; all flags 0; cur_player=0; level=0.
  - Every lives[i]=NUM_LIVES.
  - anim counter=ANIM_DIV-1.
- anim divider: free-running in all states. On vsync: if cnt>0, decrement; else reload ANIM_DIV-1 and pulse. First pulse follows the ANIM_DIVth vsync after reset.
- INTRO:
  - Each vsync with intro_cnt≠INTRO_FRAMES increments intro_cnt.
  - intro_cnt reaching ZOOM_FRAMES sets start_done.
  - A vsync with intro_cnt==INTRO_FRAMES → PLAY, game_begin<=1.
- PLAY:
  - new_level high one cycle after the first vsync seen in PLAY following entry from INTRO or RESPAWN.
  - Accepted level_clear → level+1 (saturating) and new_level the next cycle.
- die in PLAY:
  - Decrement lives[cur_player] (never below 0); game_begin<=0.
  - If the resulting lives of every player are 0 → GAME_OVER; else → RESPAWN with resp_cnt=0.
- RESPAWN:
  - Counts vsyncs; the vsync with resp_cnt==RESPAWN_FRAMES-1 → PLAY.
  - On that exit, cur_player advances round-robin to the next index (wrapping) with lives>0. It may remain the same player.
- GAME_OVER:
  - game_over=1; start_done held 1.
  - restart → INTRO: intro_cnt=0, start_done=0, lives reload NUM_LIVES, level=0, cur_player=0.
- bonus applies to lives[cur_player] in any state except GAME_OVER, saturating at MAX_NUM_LIVES.
- Simultaneous events:
  - die+bonus: net lives change 0, RESPAWN still entered.
  - die+level_clear: die wins; level_clear dropped.
  - die/level_clear outside PLAY: ignored.
  - restart outside GAME_OVER: ignored.
  - vsync and die in the same cycle: die takes effect; the counter starts at the next vsync.
- NUM_PLAYERS=1: cur_player constant 0, RESPAWN returns to the same player.
- Reset mid-operation: immediate return to reset values; pending pulses are lost.

Optional Feature:
GAME_FLOW_PAUSE_EN:
- Defined: adds input pause (pulse) and state PAUSE.
  - pause in PLAY → PAUSE; pause in PAUSE → PLAY.
  - In PAUSE: game_begin=0, anim divider frozen, die/level_clear/bonus ignored.
  - new_level is not re-issued on resume.
- Undefined: no port, no state; the encoding still reserves the PAUSE value.

Decomposition:
- Package asteroids holds:
  - typedef enum logic [2:0] game_state_t {INTRO, PLAY, RESPAWN, GAME_OVER, PAUSE}.
  - Default localparams NUM_LIVES and MAX_NUM_LIVES.
- Sub-module vsync_divider (parameter DIV): instantiated for anim_pulse, with a freeze input tied high only when GAME_FLOW_PAUSE_EN pauses.

Test Plan:
1. Reset with INTRO_FRAMES=8, ZOOM_FRAMES=4 → start_done rises after vsync 4; PLAY entered on vsync 9; new_level pulses once, after vsync 10.
2. ANIM_DIV=3, 9 vsyncs → exactly 3 anim_pulse, each one cycle, after vsyncs 3, 6, 9.
3. NUM_PLAYERS=2, RESPAWN_FRAMES=2; die in PLAY → lives={3,2}; RESPAWN; PLAY after 2 vsyncs; cur_player=1.
4. Player 0 at 0 lives, player 1 at 1 life, die → GAME_OVER, game_over=1. restart → INTRO, lives={3,3}, level=0.
5. lives=10, bonus → stays 10. die+bonus same cycle at lives=2 → lives=2, state RESPAWN.
6. die and level_clear in the same cycle at level=5 → level=5, no new_level. Then level_clear in PLAY → level=6, new_level for one cycle.

Source files
------------

// File: rtl/game_flow_ctrl_pkg.sv
// asteroids: game-state encoding and default life limits shared by the game-flow logic.
package asteroids;
    typedef enum logic [2:0] {INTRO, PLAY, RESPAWN, GAME_OVER, PAUSE} game_state_t;
    localparam int NUM_LIVES = 3;
    localparam int MAX_NUM_LIVES = 10;
endpackage

// File: rtl/game_flow_ctrl_vsync_divider.sv
// vsync_divider: emits a one-cycle pulse every DIV vsyncs; freeze holds the count.
module vsync_divider #(
    parameter int DIV = 12
) (
    input  logic clk,
    input  logic resetN,
    input  logic vsync,
    input  logic freeze,
    output logic pulse
);
    localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
    logic [CW-1:0] cnt;
    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt <= CW'(DIV - 1);
            pulse <= 1'b0;
        end else begin
            pulse <= 1'b0;
            if (vsync && !freeze) begin
                cnt <= (cnt != '0) ? cnt - CW'(1) : CW'(DIV - 1);
                pulse <= (cnt == '0);
            end
        end
    end
endmodule

// File: rtl/game_flow_ctrl.sv
// game_flow_ctrl: frame-synchronous intro/play/respawn/game-over flow for N alternating players.
// Defining GAME_FLOW_PAUSE_EN adds a pause input toggling PLAY <-> PAUSE.
module game_flow_ctrl import asteroids::*; #(
    parameter int NUM_PLAYERS = 2,
    parameter int NUM_LIVES = asteroids::NUM_LIVES,
    parameter int MAX_NUM_LIVES = asteroids::MAX_NUM_LIVES,
    parameter int INTRO_FRAMES = 511,
    parameter int ZOOM_FRAMES = 255,
    parameter int RESPAWN_FRAMES = 120,
    parameter int ANIM_DIV = 12,
    localparam int PW = NUM_PLAYERS > 1 ? $clog2(NUM_PLAYERS) : 1,
    localparam int LW = $clog2(MAX_NUM_LIVES + 1)
) (
    input  logic                      clk,
    input  logic                      resetN,
    input  logic                      vsync,
    input  logic                      die,
    input  logic                      bonus,
    input  logic                      level_clear,
    input  logic                      restart,
`ifdef GAME_FLOW_PAUSE_EN
    input  logic                      pause,
`endif
    output game_state_t               state,
    output logic [7:0]                intro_scale,
    output logic                      start_done,
    output logic                      game_begin,
    output logic                      new_level,
    output logic                      game_over,
    output logic [PW-1:0]             cur_player,
    output logic [NUM_PLAYERS*LW-1:0] lives,
    output logic [7:0]                level,
    output logic                      anim_pulse
);
    localparam int IW = $clog2(INTRO_FRAMES + 1) > 8 ? $clog2(INTRO_FRAMES + 1) : 8;
    localparam int RW = RESPAWN_FRAMES > 1 ? $clog2(RESPAWN_FRAMES) : 1;

    game_state_t   state_nxt;
    logic [IW-1:0] intro_cnt;
    logic [RW-1:0] resp_cnt;
    logic [LW-1:0] lives_r [NUM_PLAYERS];
    logic [LW-1:0] cur_lives_nxt;
    logic [PW-1:0] next_player, idx;
    logic          nl_pend, pause_i, die_ok, bonus_ok, all_dead, intro_end, resp_end;
    int            cl;

`ifdef GAME_FLOW_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    assign intro_end = vsync && intro_cnt == IW'(INTRO_FRAMES);
    assign resp_end = vsync && resp_cnt == RW'(RESPAWN_FRAMES - 1);
    assign die_ok = die && state == PLAY;
    assign bonus_ok = bonus && state != GAME_OVER && state != PAUSE;
    assign intro_scale = intro_cnt[7:0];
    assign game_begin = state == PLAY;
    assign game_over = state == GAME_OVER;

    // die and bonus net out before the all-players-dead test
    always_comb begin
        cl = int'(lives_r[cur_player]) + int'(bonus_ok) - int'(die_ok);
        cur_lives_nxt = cl < 0 ? '0 : cl > MAX_NUM_LIVES ? LW'(MAX_NUM_LIVES) : LW'(cl);
        all_dead = cur_lives_nxt == '0;
        for (int i = 0; i < NUM_PLAYERS; i++)
            if (PW'(i) != cur_player && lives_r[PW'(i)] != '0) all_dead = 1'b0;
        next_player = cur_player;
        idx = '0;
        for (int k = NUM_PLAYERS; k >= 1; k--) begin
            idx = PW'((int'(cur_player) + k) % NUM_PLAYERS);
            if (lives_r[idx] != '0) next_player = idx;
        end
    end

    always_comb begin
        lives = '0;
        for (int i = 0; i < NUM_PLAYERS; i++) lives[i*LW +: LW] = lives_r[i];
    end

    always_comb begin
        state_nxt = state;
        case (state)
            INTRO:     state_nxt = intro_end ? PLAY : INTRO;
            PLAY:      state_nxt = die_ok ? (all_dead ? GAME_OVER : RESPAWN) : pause_i ? PAUSE : PLAY;
            RESPAWN:   state_nxt = resp_end ? PLAY : RESPAWN;
            GAME_OVER: state_nxt = restart ? INTRO : GAME_OVER;
`ifdef GAME_FLOW_PAUSE_EN
            PAUSE:     state_nxt = pause_i ? PLAY : PAUSE;
`endif
            default:   state_nxt = INTRO;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state <= INTRO;
        else state <= state_nxt;
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            intro_cnt <= '0;
            resp_cnt <= '0;
            start_done <= 1'b0;
            new_level <= 1'b0;
            nl_pend <= 1'b0;
            cur_player <= '0;
            level <= '0;
            for (int i = 0; i < NUM_PLAYERS; i++) lives_r[i] <= LW'(NUM_LIVES);
        end else begin
            new_level <= 1'b0;
            if (bonus_ok || die_ok) lives_r[cur_player] <= cur_lives_nxt;
            case (state)
                INTRO: begin
                    if (vsync && !intro_end) intro_cnt <= intro_cnt + IW'(1);
                    if (vsync && !intro_end && intro_cnt + IW'(1) == IW'(ZOOM_FRAMES)) start_done <= 1'b1;
                    if (intro_end) nl_pend <= 1'b1;
                end
                PLAY: begin
                    if (die_ok) resp_cnt <= '0;
                    else begin
                        if (level_clear) begin
                            level <= (level == 8'hFF) ? level : level + 8'd1;
                            new_level <= 1'b1;
                        end
                        if (vsync && nl_pend) begin
                            new_level <= 1'b1;
                            nl_pend <= 1'b0;
                        end
                    end
                end
                RESPAWN: begin
                    if (resp_end) begin
                        cur_player <= next_player;
                        nl_pend <= 1'b1;
                    end else if (vsync) resp_cnt <= resp_cnt + RW'(1);
                end
                GAME_OVER: begin
                    start_done <= 1'b1;
                    if (restart) begin
                        intro_cnt <= '0;
                        start_done <= 1'b0;
                        level <= '0;
                        cur_player <= '0;
                        nl_pend <= 1'b0;
                        for (int i = 0; i < NUM_PLAYERS; i++) lives_r[i] <= LW'(NUM_LIVES);
                    end
                end
                default: ;
            endcase
        end
    end

    vsync_divider #(.DIV(ANIM_DIV)) u_anim (
        .clk    (clk),
        .resetN (resetN),
        .vsync  (vsync),
        .freeze (state == PAUSE),
        .pulse  (anim_pulse)
    );
endmodule
